tdm_demux_4x4: RTL and testbench
================================

Name: tdm_demux_4x4

Overview:
- 4-channel time-division demultiplexer: the receive end of a 4:1 TDM link built from the team's 4-bit 4:1 multiplexer plus a rotating 2-bit select.
- Accepts one 4-bit word per valid cycle, tags it with a channel index tracked by an internal counter, and stages each word.
- Presents all four channels atomically once a complete frame (channels 0..3) has arrived.
- Sits between the serial link and per-channel consumers.

Parameters:
- WIDTH, 4, bit width of each channel word.
- FCNT_W, 8, width of the completed-frame counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  incoming TDM word.
- din_valid  input  1  din is valid this cycle.
- sof  input  1  start of frame; qualified by din_valid; marks the word as channel 0.
- w0  output  WIDTH  channel 0 word of the last complete frame.
- w1  output  WIDTH  channel 1 word of the last complete frame.
- w2  output  WIDTH  channel 2 word of the last complete frame.
- w3  output  WIDTH  channel 3 word of the last complete frame.
- sel  output  2  channel index the next accepted word will be assigned to.
- ch_strobe  output  4  one-hot; registered pulse naming the channel just staged.
- frame_done  output  1  1-cycle pulse; w0..w3 updated this cycle.
- frame_err  output  1  1-cycle pulse on a framing violation.
- frame_cnt  output  FCNT_W  count of completed frames; wraps.

Behaviour:
- Reset (asynchronous, active-high, also mid-frame) clears:
  - w0..w3, staging registers, sel, ch_strobe, frame_done, frame_err and frame_cnt to 0.
  - State to IDLE.
  - Any partial frame is discarded.
- States:
  - IDLE: waiting for sof.
  - RECV: a frame is in progress; sel holds the next channel, 1..3.
- IDLE:
  - din_valid=1 and sof=1: stage din as channel 0, sel<=1, go to RECV.
  - din_valid=1 and sof=0: word dropped, frame_err pulses, state stays IDLE, sel stays 0.
  - din_valid=0: no action.
- RECV:
  - din_valid=0: hold all state. Idle gaps of any length are legal.
  - din_valid=1, sof=0: stage din into channel sel, sel<=sel+1.
  - When sel=3 is staged, the frame is complete:
    - w0..w3 load from staging plus this word in the same edge.
    - frame_done pulses and frame_cnt increments; FCNT_W-bit wrap, all-ones -> 0.
    - sel<=0, state to IDLE.
  - din_valid=1, sof=1 (premature sof):
    - frame_err pulses and the partial frame is discarded.
    - The sof word is staged as channel 0 of a new frame, sel<=1, state stays RECV.
    - w0..w3 unchanged.
- sof with din_valid=0 is ignored in all states.
- ch_strobe:
  - Each accepted word asserts ch_strobe[channel] for exactly the cycle after acceptance.
  - Dropped words produce no strobe.
  - The premature-sof word produces strobe bit 0.
- Latency:
  - A channel-3 word sampled at edge N drives new w0..w3 values together with frame_done from edge N, visible for cycle N+1.
  - w0..w3 are never partially updated; they hold until the next complete frame.
- Back-to-back frames: sof may arrive in the cycle immediately after a frame-completing word with no gap, giving full throughput of one word per cycle.
- frame_err and frame_done can never be high in the same cycle.

Test Plan:
- Reset then frame A,B,C,D: din_valid=1 for 4 cycles, sof on A -> ch_strobe 0001,0010,0100,1000; frame_done one cycle after D; w0..w3=A,B,C,D; frame_cnt=1.
- Gaps inside a frame: frame 1,2,3,4 with 2 idle cycles between each word -> w0..w3=1,2,3,4 after the last word only; w0..w3 keep previous values until then; sel steps 1,2,3,0.
- Premature sof: sof 5,6 then sof 7,8,9,A -> frame_err pulses at the second sof; w0..w3=7,8,9,A; frame_cnt +1 only.
- Valid without sof in IDLE: din=F, valid=1, sof=0 -> frame_err pulses, ch_strobe=0000, sel=0, outputs unchanged.
- Back-to-back and wrap: 256 consecutive frames with no gaps, FCNT_W=8 -> frame_done every 4th cycle; frame_cnt reads 0 after frame 256.
- Async reset mid-frame: assert rst between channel-1 and channel-2 words -> all outputs 0 immediately, without waiting for a clock edge; a following complete frame is received correctly with frame_cnt=1.

Source files
------------

// File: rtl/tdm_demux_4x4.sv
// Receive end of a 4-channel TDM link: tags each valid word with a rotating channel
// index, stages a frame and publishes all four channels at once on completion.
module tdm_demux_4x4 #(
    parameter int WIDTH  = 4,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  din,
    input  logic              din_valid,
    input  logic              sof,
    output logic [WIDTH-1:0]  w0,
    output logic [WIDTH-1:0]  w1,
    output logic [WIDTH-1:0]  w2,
    output logic [WIDTH-1:0]  w3,
    output logic [1:0]        sel,
    output logic [3:0]        ch_strobe,
    output logic              frame_done,
    output logic              frame_err,
    output logic [FCNT_W-1:0] frame_cnt
);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t              state_q;
    logic [1:0]          sel_q;
    logic [WIDTH-1:0]    stg0_q;
    logic [WIDTH-1:0]    stg1_q;
    logic [WIDTH-1:0]    stg2_q;
    logic [WIDTH-1:0]    w0_q;
    logic [WIDTH-1:0]    w1_q;
    logic [WIDTH-1:0]    w2_q;
    logic [WIDTH-1:0]    w3_q;
    logic [3:0]          strobe_q;
    logic                done_q;
    logic                err_q;
    logic [FCNT_W-1:0]   cnt_q;

    logic [FCNT_W-1:0]   cnt_d;
    logic [3:0]          strobe_d;

    function automatic logic [3:0] chan_onehot(input logic [1:0] ch);
        return 4'b0001 << ch;
    endfunction

    assign cnt_d    = cnt_q + FCNT_W'(1);
    assign strobe_d = chan_onehot(sel_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= 2'd0;
            stg0_q   <= '0;
            stg1_q   <= '0;
            stg2_q   <= '0;
            w0_q     <= '0;
            w1_q     <= '0;
            w2_q     <= '0;
            w3_q     <= '0;
            strobe_q <= 4'b0000;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            // Status outputs are single-cycle pulses unless re-asserted below.
            strobe_q <= 4'b0000;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            if (din_valid) begin
                if (sof) begin
                    // A sof seen mid-frame abandons the partial frame but still starts a new one.
                    err_q    <= (state_q == RECV);
                    stg0_q   <= din;
                    sel_q    <= 2'd1;
                    strobe_q <= 4'b0001;
                    state_q  <= RECV;
                end else if (state_q == IDLE) begin
                    err_q <= 1'b1;
                end else begin
                    strobe_q <= strobe_d;
                    case (sel_q)
                        2'd1: begin
                            stg1_q <= din;
                            sel_q  <= 2'd2;
                        end
                        2'd2: begin
                            stg2_q <= din;
                            sel_q  <= 2'd3;
                        end
                        default: begin
                            w0_q    <= stg0_q;
                            w1_q    <= stg1_q;
                            w2_q    <= stg2_q;
                            w3_q    <= din;
                            done_q  <= 1'b1;
                            cnt_q   <= cnt_d;
                            sel_q   <= 2'd0;
                            state_q <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign w0         = w0_q;
    assign w1         = w1_q;
    assign w2         = w2_q;
    assign w3         = w3_q;
    assign sel        = sel_q;
    assign ch_strobe  = strobe_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_tdm_demux_4x4.sv
// Directed bench for tdm_demux_4x4: inputs change on the falling edge, outputs are
// checked on the following falling edge, i.e. after the rising edge that consumed them.
module tb_tdm_demux_4x4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic       din_valid;
    logic       sof;
    logic [3:0] w0;
    logic [3:0] w1;
    logic [3:0] w2;
    logic [3:0] w3;
    logic [1:0] sel;
    logic [3:0] ch_strobe;
    logic       frame_done;
    logic       frame_err;
    logic [7:0] frame_cnt;

    int errs   = 0;
    int checks = 0;

    tdm_demux_4x4 #(.WIDTH(4), .FCNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sof        (sof),
        .w0         (w0),
        .w1         (w1),
        .w2         (w2),
        .w3         (w3),
        .sel        (sel),
        .ch_strobe  (ch_strobe),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    // Present one input cycle starting at a falling edge; return at the next falling edge.
    task automatic cycle(input logic v, input logic s, input logic [3:0] d);
        din_valid = v;
        sof       = s;
        din       = d;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        sof = 1'b0;
        din = 4'h0;
        repeat (2) @(negedge clk);
        checks++;
        if ({w0, w1, w2, w3, sel, ch_strobe, frame_done, frame_err, frame_cnt} !== 32'h0) begin
            errs++;
            $display("FAIL reset_outputs: got w=%h%h%h%h sel=%0d strobe=%b done=%b err=%b cnt=%0d, expected all 0",
                     w0, w1, w2, w3, sel, ch_strobe, frame_done, frame_err, frame_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_frame();
        logic [3:0] exp_strobe [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [1:0] exp_sel    [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] data       [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, i == 0, data[i]);
            checks++;
            if (ch_strobe !== exp_strobe[i]) begin
                errs++;
                $display("FAIL basic_strobe[%0d]: got %b expected %b", i, ch_strobe, exp_strobe[i]);
            end
            checks++;
            if (sel !== exp_sel[i]) begin
                errs++;
                $display("FAIL basic_sel[%0d]: got %0d expected %0d", i, sel, exp_sel[i]);
            end
            checks++;
            if (frame_done !== (i == 3)) begin
                errs++;
                $display("FAIL basic_done[%0d]: got %b expected %b", i, frame_done, i == 3);
            end
        end
        checks++;
        if ({w0, w1, w2, w3} !== 16'hABCD || frame_cnt !== 8'd1) begin
            errs++;
            $display("FAIL basic_words: got w=%h%h%h%h cnt=%0d expected w=ABCD cnt=1", w0, w1, w2, w3, frame_cnt);
        end
        cycle(1'b0, 1'b0, 4'h0);
        checks++;
        if (frame_done !== 1'b0 || ch_strobe !== 4'b0000) begin
            errs++;
            $display("FAIL basic_pulse_end: got done=%b strobe=%b expected 0 and 0000", frame_done, ch_strobe);
        end
    endtask

    task automatic test_gaps();
        logic [1:0] exp_sel [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, i == 0, 4'(i + 1));
            checks++;
            if (sel !== exp_sel[i]) begin
                errs++;
                $display("FAIL gap_sel[%0d]: got %0d expected %0d", i, sel, exp_sel[i]);
            end
            repeat (2) cycle(1'b0, 1'b0, 4'h0);
            checks++;
            if (sel !== exp_sel[i] || ch_strobe !== 4'b0000 || frame_done !== 1'b0) begin
                errs++;
                $display("FAIL gap_hold[%0d]: got sel=%0d strobe=%b done=%b expected sel=%0d strobe=0000 done=0",
                         i, sel, ch_strobe, frame_done, exp_sel[i]);
            end
            if (i < 3) begin
                checks++;
                if ({w0, w1, w2, w3} !== 16'hABCD) begin
                    errs++;
                    $display("FAIL gap_words_held[%0d]: got %h%h%h%h expected ABCD", i, w0, w1, w2, w3);
                end
            end
        end
        checks++;
        if ({w0, w1, w2, w3} !== 16'h1234 || frame_cnt !== 8'd2) begin
            errs++;
            $display("FAIL gap_words: got w=%h%h%h%h cnt=%0d expected w=1234 cnt=2", w0, w1, w2, w3, frame_cnt);
        end
    endtask

    task automatic test_premature_sof();
        cycle(1'b1, 1'b1, 4'h5);
        cycle(1'b1, 1'b0, 4'h6);
        checks++;
        if (frame_err !== 1'b0) begin
            errs++;
            $display("FAIL premature_no_err_early: got %b expected 0", frame_err);
        end
        cycle(1'b1, 1'b1, 4'h7);
        checks++;
        if (frame_err !== 1'b1 || ch_strobe !== 4'b0001 || sel !== 2'd1) begin
            errs++;
            $display("FAIL premature_err: got err=%b strobe=%b sel=%0d expected err=1 strobe=0001 sel=1",
                     frame_err, ch_strobe, sel);
        end
        checks++;
        if ({w0, w1, w2, w3} !== 16'h1234) begin
            errs++;
            $display("FAIL premature_words_held: got %h%h%h%h expected 1234", w0, w1, w2, w3);
        end
        cycle(1'b1, 1'b0, 4'h8);
        checks++;
        if (frame_err !== 1'b0) begin
            errs++;
            $display("FAIL premature_err_pulse: got %b expected 0", frame_err);
        end
        cycle(1'b1, 1'b0, 4'h9);
        cycle(1'b1, 1'b0, 4'hA);
        checks++;
        if (frame_done !== 1'b1 || frame_err !== 1'b0 || {w0, w1, w2, w3} !== 16'h789A || frame_cnt !== 8'd3) begin
            errs++;
            $display("FAIL premature_frame: got done=%b err=%b w=%h%h%h%h cnt=%0d expected done=1 err=0 w=789A cnt=3",
                     frame_done, frame_err, w0, w1, w2, w3, frame_cnt);
        end
    endtask

    task automatic test_idle_valid();
        cycle(1'b1, 1'b0, 4'hF);
        checks++;
        if (frame_err !== 1'b1 || ch_strobe !== 4'b0000 || sel !== 2'd0) begin
            errs++;
            $display("FAIL idle_drop: got err=%b strobe=%b sel=%0d expected err=1 strobe=0000 sel=0",
                     frame_err, ch_strobe, sel);
        end
        checks++;
        if ({w0, w1, w2, w3} !== 16'h789A || frame_cnt !== 8'd3 || frame_done !== 1'b0) begin
            errs++;
            $display("FAIL idle_outputs_held: got w=%h%h%h%h cnt=%0d done=%b expected w=789A cnt=3 done=0",
                     w0, w1, w2, w3, frame_cnt, frame_done);
        end
        cycle(1'b0, 1'b0, 4'h0);
        checks++;
        if (frame_err !== 1'b0) begin
            errs++;
            $display("FAIL idle_err_pulse: got %b expected 0", frame_err);
        end
    endtask

    task automatic test_sof_without_valid();
        cycle(1'b0, 1'b1, 4'h5);
        checks++;
        if (sel !== 2'd0 || ch_strobe !== 4'b0000 || frame_err !== 1'b0) begin
            errs++;
            $display("FAIL sof_novalid: got sel=%0d strobe=%b err=%b expected sel=0 strobe=0000 err=0",
                     sel, ch_strobe, frame_err);
        end
        // Still in IDLE, so a plain valid word must be rejected.
        cycle(1'b1, 1'b0, 4'h1);
        checks++;
        if (frame_err !== 1'b1 || ch_strobe !== 4'b0000) begin
            errs++;
            $display("FAIL sof_novalid_still_idle: got err=%b strobe=%b expected err=1 strobe=0000", frame_err, ch_strobe);
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 1'b1, 4'h1);
        cycle(1'b1, 1'b0, 4'h2);
        din_valid = 1'b0;
        sof = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({w0, w1, w2, w3, sel, ch_strobe, frame_done, frame_err, frame_cnt} !== 32'h0) begin
            errs++;
            $display("FAIL async_reset: got w=%h%h%h%h sel=%0d strobe=%b done=%b err=%b cnt=%0d expected all 0",
                     w0, w1, w2, w3, sel, ch_strobe, frame_done, frame_err, frame_cnt);
        end
        #1 rst = 1'b0;
        cycle(1'b1, 1'b0, 4'h7);
        checks++;
        if (frame_err !== 1'b1 || sel !== 2'd0) begin
            errs++;
            $display("FAIL async_reset_idle: got err=%b sel=%0d expected err=1 sel=0", frame_err, sel);
        end
        cycle(1'b1, 1'b1, 4'h3);
        cycle(1'b1, 1'b0, 4'h4);
        cycle(1'b1, 1'b0, 4'h5);
        cycle(1'b1, 1'b0, 4'h6);
        checks++;
        if ({w0, w1, w2, w3} !== 16'h3456 || frame_cnt !== 8'd1 || frame_done !== 1'b1) begin
            errs++;
            $display("FAIL async_reset_recover: got w=%h%h%h%h cnt=%0d done=%b expected w=3456 cnt=1 done=1",
                     w0, w1, w2, w3, frame_cnt, frame_done);
        end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        #1 rst = 1'b0;
        for (int f = 0; f < 256; f++) begin
            for (int k = 0; k < 4; k++) begin
                cycle(1'b1, k == 0, 4'(f + k));
                checks++;
                if (frame_done !== (k == 3) || frame_err !== 1'b0) begin
                    errs++;
                    $display("FAIL b2b_done f=%0d k=%0d: got done=%b err=%b expected done=%b err=0",
                             f, k, frame_done, frame_err, k == 3);
                end
            end
            if (f == 254) begin
                checks++;
                if (frame_cnt !== 8'd255) begin
                    errs++;
                    $display("FAIL b2b_cnt_255: got %0d expected 255", frame_cnt);
                end
            end
        end
        checks++;
        if (frame_cnt !== 8'd0) begin
            errs++;
            $display("FAIL b2b_cnt_wrap: got %0d expected 0", frame_cnt);
        end
        checks++;
        if ({w0, w1, w2, w3} !== 16'hF012) begin
            errs++;
            $display("FAIL b2b_last_words: got %h%h%h%h expected F012", w0, w1, w2, w3);
        end
        cycle(1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_gaps();
        test_premature_sof();
        test_idle_valid();
        test_sof_without_valid();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
